// File: rtl/decode_stage.sv
// Decode stage of a Y86-64 style pipeline: register-ID selection, operand
// forwarding, load/use detection and the execute-stage pipeline register.
module decode_stage (
    input  logic        clock,
    input  logic        reset,
    // Decode-stage pipeline register contents
    input  logic [2:0]  D_stat,
    input  logic [3:0]  D_icode,
    input  logic [3:0]  D_ifun,
    input  logic [3:0]  D_rA,
    input  logic [3:0]  D_rB,
    input  logic [63:0] D_valC,
    input  logic [63:0] D_valP,
    // Register file read port
    output logic [3:0]  d_srcA,
    output logic [3:0]  d_srcB,
    input  logic [63:0] d_rvalA,
    input  logic [63:0] d_rvalB,
    // Forwarding sources, youngest first
    input  logic [3:0]  e_dstE,
    input  logic [63:0] e_valE,
    input  logic [3:0]  M_dstM,
    input  logic [63:0] m_valM,
    input  logic [3:0]  M_dstE,
    input  logic [63:0] M_valE,
    input  logic [3:0]  W_dstM,
    input  logic [63:0] W_valM,
    input  logic [3:0]  W_dstE,
    input  logic [63:0] W_valE,
    // Execute register control
    input  logic        E_stall,
    input  logic        E_bubble,
    // Execute-stage register outputs
    output logic [2:0]  E_stat,
    output logic [3:0]  E_icode,
    output logic [3:0]  E_ifun,
    output logic [63:0] E_valC,
    output logic [63:0] E_valA,
    output logic [63:0] E_valB,
    output logic [3:0]  E_dstE,
    output logic [3:0]  E_dstM,
    output logic [3:0]  E_srcA,
    output logic [3:0]  E_srcB,
    output logic        d_loaduse
);

    localparam logic [3:0] HALT   = 4'h0;
    localparam logic [3:0] NOP    = 4'h1;
    localparam logic [3:0] RRMOVQ = 4'h2;
    localparam logic [3:0] IRMOVQ = 4'h3;
    localparam logic [3:0] RMMOVQ = 4'h4;
    localparam logic [3:0] MRMOVQ = 4'h5;
    localparam logic [3:0] OPQ    = 4'h6;
    localparam logic [3:0] JXX    = 4'h7;
    localparam logic [3:0] CALL   = 4'h8;
    localparam logic [3:0] RET    = 4'h9;
    localparam logic [3:0] PUSHQ  = 4'hA;
    localparam logic [3:0] POPQ   = 4'hB;
    localparam logic [3:0] RSP    = 4'h4;
    localparam logic [3:0] RNONE  = 4'hF;
    localparam logic [2:0] SAOK   = 3'd1;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valC;
        logic [63:0] valA;
        logic [63:0] valB;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [3:0]  srcA;
        logic [3:0]  srcB;
    } eReg_t;

    localparam eReg_t BUBBLE = '{
        stat:  SAOK,
        icode: NOP,
        ifun:  4'h0,
        valC:  64'd0,
        valA:  64'd0,
        valB:  64'd0,
        dstE:  RNONE,
        dstM:  RNONE,
        srcA:  RNONE,
        srcB:  RNONE
    };

    logic [3:0]  d_dstE;
    logic [3:0]  d_dstM;
    logic [63:0] d_valA;
    logic [63:0] d_valB;
    eReg_t       eCur;
    eReg_t       eNext;

    // Register ID selection from the instruction class
    always_comb begin
        unique case (D_icode)
            RRMOVQ, RMMOVQ, OPQ, PUSHQ: d_srcA = D_rA;
            POPQ, RET:                  d_srcA = RSP;
            default:                    d_srcA = RNONE;
        endcase
    end

    always_comb begin
        unique case (D_icode)
            OPQ, RMMOVQ, MRMOVQ:        d_srcB = D_rB;
            PUSHQ, POPQ, CALL, RET:     d_srcB = RSP;
            default:                    d_srcB = RNONE;
        endcase
    end

    always_comb begin
        unique case (D_icode)
            RRMOVQ, IRMOVQ, OPQ:        d_dstE = D_rB;
            PUSHQ, POPQ, CALL, RET:     d_dstE = RSP;
            default:                    d_dstE = RNONE;
        endcase
    end

    always_comb begin
        unique case (D_icode)
            MRMOVQ, POPQ:               d_dstM = D_rA;
            default:                    d_dstM = RNONE;
        endcase
    end

    // One forwarding mux per read port; RNONE never matches a destination
    // so unused ports always see the register file value.
    for (genvar gi = 0; gi < 2; gi++) begin : gFwd
        logic [3:0]  src;
        logic [63:0] rfVal;
        logic [63:0] val;

        assign src   = (gi == 0) ? d_srcA  : d_srcB;
        assign rfVal = (gi == 0) ? d_rvalA : d_rvalB;

        always_comb begin
            if (src == RNONE)        val = rfVal;
            else if (src == e_dstE)  val = e_valE;
            else if (src == M_dstM)  val = m_valM;
            else if (src == M_dstE)  val = M_valE;
            else if (src == W_dstM)  val = W_valM;
            else if (src == W_dstE)  val = W_valE;
            else                     val = rfVal;
        end
    end

    // Control transfers carry the fall-through PC down the valA path
    assign d_valA = (D_icode == CALL || D_icode == JXX) ? D_valP : gFwd[0].val;
    assign d_valB = gFwd[1].val;

    assign d_loaduse = (E_icode == MRMOVQ || E_icode == POPQ) &&
                       (E_dstM != RNONE) &&
                       (E_dstM == d_srcA || E_dstM == d_srcB);

    // Stall outranks bubble
    always_comb begin
        eNext = eCur;
        if (E_stall) begin
            eNext = eCur;
        end else if (E_bubble) begin
            eNext = BUBBLE;
        end else begin
            eNext.stat  = D_stat;
            eNext.icode = D_icode;
            eNext.ifun  = D_ifun;
            eNext.valC  = D_valC;
            eNext.valA  = d_valA;
            eNext.valB  = d_valB;
            eNext.dstE  = d_dstE;
            eNext.dstM  = d_dstM;
            eNext.srcA  = d_srcA;
            eNext.srcB  = d_srcB;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) eCur <= BUBBLE;
        else        eCur <= eNext;
    end

    assign E_stat  = eCur.stat;
    assign E_icode = eCur.icode;
    assign E_ifun  = eCur.ifun;
    assign E_valC  = eCur.valC;
    assign E_valA  = eCur.valA;
    assign E_valB  = eCur.valB;
    assign E_dstE  = eCur.dstE;
    assign E_dstM  = eCur.dstM;
    assign E_srcA  = eCur.srcA;
    assign E_srcB  = eCur.srcB;

    // HALT is decoded only through the default arms above
    logic unusedHalt;
    assign unusedHalt = (D_icode == HALT);

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected values are queued as each step is
// driven and popped for comparison once the DUT result is due.
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  D_stat;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
    logic [3:0]  d_srcA, d_srcB;
    logic [63:0] d_rvalA, d_rvalB;
    logic [3:0]  e_dstE, M_dstM, M_dstE, W_dstM, W_dstE;
    logic [63:0] e_valE, m_valM, M_valE, W_valM, W_valE;
    logic        E_stall, E_bubble;
    logic [2:0]  E_stat;
    logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
    logic [63:0] E_valC, E_valA, E_valB;
    logic        d_loaduse;

    decode_stage dut (
        .clock(clock), .reset(reset),
        .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .d_rvalA(d_rvalA), .d_rvalB(d_rvalB),
        .e_dstE(e_dstE), .e_valE(e_valE), .M_dstM(M_dstM), .m_valM(m_valM),
        .M_dstE(M_dstE), .M_valE(M_valE), .W_dstM(W_dstM), .W_valM(W_valM),
        .W_dstE(W_dstE), .W_valE(W_valE),
        .E_stall(E_stall), .E_bubble(E_bubble),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC),
        .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM),
        .E_srcA(E_srcA), .E_srcB(E_srcB), .d_loaduse(d_loaduse)
    );

    always #5 clock = ~clock;

    localparam int F_STAT = 0, F_ICODE = 1, F_IFUN = 2, F_VALC = 3, F_VALA = 4,
                   F_VALB = 5, F_DSTE = 6, F_DSTM = 7, F_SRCA = 8, F_SRCB = 9,
                   F_LU = 10, F_DSRCA = 11, F_DSRCB = 12;

    typedef struct {
        int          field;
        logic [63:0] exp;
        string       tag;
    } expect_t;

    expect_t sbq[$];
    int testsRun = 0;
    int testsFailed = 0;

    function automatic logic [63:0] observe(input int field);
        case (field)
            F_STAT:  return {61'd0, E_stat};
            F_ICODE: return {60'd0, E_icode};
            F_IFUN:  return {60'd0, E_ifun};
            F_VALC:  return E_valC;
            F_VALA:  return E_valA;
            F_VALB:  return E_valB;
            F_DSTE:  return {60'd0, E_dstE};
            F_DSTM:  return {60'd0, E_dstM};
            F_SRCA:  return {60'd0, E_srcA};
            F_SRCB:  return {60'd0, E_srcB};
            F_LU:    return {63'd0, d_loaduse};
            F_DSRCA: return {60'd0, d_srcA};
            F_DSRCB: return {60'd0, d_srcB};
            default: return 64'hDEAD;
        endcase
    endfunction

    task automatic push(input int field, input logic [63:0] exp, input string tag);
        expect_t e;
        e.field = field;
        e.exp   = exp;
        e.tag   = tag;
        sbq.push_back(e);
    endtask

    task automatic drain();
        expect_t e;
        logic [63:0] obs;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            obs = observe(e.field);
            testsRun++;
            assert (obs === e.exp) else begin
                testsFailed++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic setD(input logic [3:0] icode, input logic [3:0] ifun,
                        input logic [3:0] rA, input logic [3:0] rB,
                        input logic [63:0] valC, input logic [63:0] valP);
        D_stat = 3'd1; D_icode = icode; D_ifun = ifun;
        D_rA = rA; D_rB = rB; D_valC = valC; D_valP = valP;
    endtask

    task automatic clearFwd();
        e_dstE = 4'hF; M_dstM = 4'hF; M_dstE = 4'hF; W_dstM = 4'hF; W_dstE = 4'hF;
        e_valE = 64'hE0; m_valM = 64'hA0; M_valE = 64'hB0; W_valM = 64'hC0; W_valE = 64'hD0;
    endtask

    task automatic edgeAndCheck();
        @(posedge clock);
        #1;
        drain();
    endtask

    initial begin
        reset = 1'b1;
        E_stall = 1'b0; E_bubble = 1'b0;
        d_rvalA = 64'h0; d_rvalB = 64'h0;
        clearFwd();
        setD(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
        @(posedge clock); #1;

        $display("[TB] load IRMOVQ rB=3 valC=0x55");
        setD(4'h3, 4'h0, 4'hF, 4'h3, 64'h55, 64'h0);
        push(F_ICODE, 64'h3, "irmovq_icode");
        push(F_DSTE, 64'h3, "irmovq_dstE");
        push(F_VALC, 64'h55, "irmovq_valC");
        edgeAndCheck();

        $display("[TB] async reset between edges");
        reset = 1'b0;
        #1;
        push(F_ICODE, 64'h1, "reset_icode");
        push(F_DSTE, 64'hF, "reset_dstE");
        push(F_VALA, 64'h0, "reset_valA");
        push(F_VALC, 64'h0, "reset_valC");
        push(F_STAT, 64'h1, "reset_stat");
        push(F_SRCA, 64'hF, "reset_srcA");
        drain();
        E_stall = 1'b1;
        setD(4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 64'h0);
        push(F_ICODE, 64'h1, "reset_held_icode");
        edgeAndCheck();
        reset = 1'b1;
        E_stall = 1'b0;

        $display("[TB] OPQ rA=2 rB=3 no forwarding");
        d_rvalA = 64'd5; d_rvalB = 64'd7;
        setD(4'h6, 4'h1, 4'h2, 4'h3, 64'h0, 64'h0);
        #1;
        push(F_DSRCA, 64'h2, "opq_d_srcA");
        push(F_DSRCB, 64'h3, "opq_d_srcB");
        drain();
        push(F_VALA, 64'd5, "opq_valA");
        push(F_VALB, 64'd7, "opq_valB");
        push(F_DSTE, 64'h3, "opq_dstE");
        push(F_DSTM, 64'hF, "opq_dstM");
        push(F_ICODE, 64'h6, "opq_icode");
        push(F_IFUN, 64'h1, "opq_ifun");
        edgeAndCheck();

        $display("[TB] forwarding priority e > M_dstM > M_dstE > W");
        setD(4'h6, 4'h0, 4'h2, 4'h5, 64'h0, 64'h0);
        e_dstE = 4'h2; e_valE = 64'd11;
        M_dstM = 4'h2; m_valM = 64'd22;
        W_dstE = 4'h2; W_valE = 64'd33;
        M_dstE = 4'h5; M_valE = 64'd55;
        W_dstM = 4'h5; W_valM = 64'd44;
        push(F_VALA, 64'd11, "fwd_eValE");
        push(F_VALB, 64'd55, "fwd_MValE_over_WValM");
        edgeAndCheck();
        e_dstE = 4'hF;
        push(F_VALA, 64'd22, "fwd_mValM");
        edgeAndCheck();
        M_dstM = 4'hF;
        push(F_VALA, 64'd33, "fwd_WValE");
        M_dstE = 4'hF;
        push(F_VALB, 64'd44, "fwd_WValM");
        edgeAndCheck();

        $display("[TB] RNONE source never forwards");
        clearFwd();
        e_valE = 64'h99;
        d_rvalA = 64'h77; d_rvalB = 64'h88;
        setD(4'h3, 4'h0, 4'hF, 4'h1, 64'h0, 64'h0);
        push(F_VALA, 64'h77, "rnone_valA");
        push(F_VALB, 64'h88, "rnone_valB");
        edgeAndCheck();

        $display("[TB] CALL valP=0x100");
        setD(4'h8, 4'h0, 4'hF, 4'hF, 64'h0, 64'h100);
        push(F_VALA, 64'h100, "call_valA");
        push(F_SRCB, 64'h4, "call_srcB");
        push(F_DSTE, 64'h4, "call_dstE");
        push(F_SRCA, 64'hF, "call_srcA");
        edgeAndCheck();

        $display("[TB] JXX valP=0x240");
        setD(4'h7, 4'h3, 4'hF, 4'hF, 64'h0, 64'h240);
        push(F_VALA, 64'h240, "jxx_valA");
        push(F_DSTE, 64'hF, "jxx_dstE");
        edgeAndCheck();

        $display("[TB] POPQ rA=7 with M_dstE=RSP");
        setD(4'hB, 4'h0, 4'h7, 4'hF, 64'h0, 64'h0);
        M_dstE = 4'h4; M_valE = 64'h200;
        W_dstE = 4'h4; W_valE = 64'h300;
        push(F_SRCA, 64'h4, "popq_srcA");
        push(F_SRCB, 64'h4, "popq_srcB");
        push(F_DSTE, 64'h4, "popq_dstE");
        push(F_DSTM, 64'h7, "popq_dstM");
        push(F_VALA, 64'h200, "popq_valA");
        push(F_VALB, 64'h200, "popq_valB");
        edgeAndCheck();
        clearFwd();
        setD(4'h2, 4'h0, 4'h7, 4'h1, 64'h0, 64'h0);
        #1;
        push(F_LU, 64'h1, "popq_loaduse");
        drain();

        $display("[TB] MRMOVQ rA=6 then load/use and stall+bubble");
        d_rvalA = 64'h1234; d_rvalB = 64'h5678;
        setD(4'h5, 4'h0, 4'h6, 4'h1, 64'h40, 64'h0);
        push(F_ICODE, 64'h5, "mrmovq_icode");
        push(F_DSTM, 64'h6, "mrmovq_dstM");
        push(F_VALB, 64'h5678, "mrmovq_valB");
        edgeAndCheck();
        setD(4'h6, 4'h0, 4'h6, 4'h2, 64'h0, 64'h0);
        #1;
        push(F_LU, 64'h1, "loaduse_srcA");
        drain();
        setD(4'h6, 4'h0, 4'h1, 4'h6, 64'h0, 64'h0);
        #1;
        push(F_LU, 64'h1, "loaduse_srcB");
        drain();
        setD(4'h6, 4'h0, 4'h1, 4'h2, 64'h0, 64'h0);
        #1;
        push(F_LU, 64'h0, "loaduse_nomatch");
        drain();
        setD(4'h6, 4'h0, 4'h6, 4'h2, 64'h0, 64'h0);
        E_stall = 1'b1; E_bubble = 1'b1;
        push(F_ICODE, 64'h5, "stall_icode");
        push(F_DSTM, 64'h6, "stall_dstM");
        push(F_VALC, 64'h40, "stall_valC");
        push(F_VALB, 64'h5678, "stall_valB");
        edgeAndCheck();

        $display("[TB] bubble alone with IRMOVQ in D");
        E_stall = 1'b0; E_bubble = 1'b1;
        setD(4'h3, 4'h0, 4'hF, 4'h2, 64'h9, 64'h0);
        D_stat = 3'd2;
        push(F_ICODE, 64'h1, "bubble_icode");
        push(F_DSTE, 64'hF, "bubble_dstE");
        push(F_STAT, 64'h1, "bubble_stat");
        push(F_VALC, 64'h0, "bubble_valC");
        push(F_LU, 64'h0, "bubble_loaduse");
        edgeAndCheck();

        $display("[TB] normal load of stat after bubble");
        E_bubble = 1'b0;
        push(F_STAT, 64'h2, "load_stat");
        push(F_DSTE, 64'h2, "load_dstE");
        edgeAndCheck();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
